rip_dmem_responder: RTL and testbench
=====================================

// Module: rip_dmem_responder
// PURPOSE
//  Memory-side responder for the core's load/store port: accepts one request at a time over a
//  valid/ready channel and returns one response per request.
//  Holds a byte-enabled data RAM, does lane steering for stores and sign/zero extension for loads.
//  Inserts configurable wait states so the pipeline's stall path is exercised against a slow memory.
// PARAMETERS
//  BASE_ADDR    32'h0001_0000  byte address of word 0
//  DEPTH        4096           RAM depth in 32-bit words (power of two)
//  WAIT_CYCLES  0              extra cycles between accept and RAM access (0..15)
// PORTS
//  CLK        in   1   clock, all logic on rising edge
//  RST        in   1   synchronous, active-high reset
//  REQ_VALID  in   1   request present
//  REQ_READY  out  1   responder can accept; high only in IDLE
//  REQ_WE     in   1   1 = store, 0 = load
//  REQ_FUNCT3 in   3   RV32I funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  REQ_ADDR   in   32  byte address
//  REQ_WDATA  in   32  store data, LSB-aligned
//  RSP_VALID  out  1   response present; held until accepted
//  RSP_READY  in   1   consumer accepts response
//  RSP_RDATA  out  32  extended load data; 0 for stores and errors
//  RSP_ERR    out  1   bad funct3, out-of-range, or misaligned (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, wait counter 0.
//   RAM contents are not cleared.
//  FSM: IDLE -> (WAIT_CYCLES>0 ? WAIT : ACCESS) -> RESP -> IDLE.
//   IDLE: on REQ_VALID&REQ_READY, register WE/FUNCT3/ADDR/WDATA and load the counter.
//   WAIT: decrement the counter each cycle; go to ACCESS on the cycle it reads 1.
//   ACCESS: error check; perform the masked write, or issue the synchronous read. Goes to RESP.
//   RESP: RSP_VALID=1 with stable RDATA/ERR; on RSP_READY go to IDLE.
//  Latency: accept edge to first RSP_VALID cycle = WAIT_CYCLES+2 cycles.
//   Back-to-back requests take one IDLE cycle between them.
//  Address: offset = ADDR-BASE_ADDR (32-bit, wraps). In range iff offset < 4*DEPTH.
//   Word index = offset[$clog2(DEPTH)+1:2]; lane = ADDR[1:0].
//  Stores: SB writes byte lane `lane` with WDATA[7:0]. SH writes lanes {lane[1],0}/+1 with WDATA[15:0].
//   SW writes all four lanes. Lanes not written keep their old value.
//  Loads: select byte/half by lane. LB/LH sign-extend; LBU/LHU zero-extend; LW unmodified.
//  Errors (RSP_ERR=1): funct3 not one of the eight legal codes, or out of range.
//   On error: no RAM write, RSP_RDATA=0, response still issued at normal latency.
//  REQ_VALID while not in IDLE is ignored (REQ_READY=0); the requester must hold it.
//  Reset in WAIT: the request is dropped with no write.
//   Reset in ACCESS on the same edge as the write: the write completes; the response is dropped.
// CONFIGURATION
//  RIP_DMEM_MISALIGN_TRAP_EN
//   Defined: LH/LHU/SH with ADDR[0]=1, or LW/SW with ADDR[1:0]!=0, give RSP_ERR=1.
//    No write, RDATA=0.
//   Undefined: misalignment is not an error. ADDR[0] is ignored for halves,
//    ADDR[1:0] for words (forced to natural alignment).
// STRUCTURE
//  Package rip_mem_pkg: funct3 localparams (F3_B/H/W/BU/HU), typedef enum logic [1:0]
//   dmem_state_t {IDLE,WAIT,ACCESS,RESP}, typedef struct mem_req_t {we,funct3,addr,wdata}.
//  Sub-module rip_dmem_bank: DEPTH x 32 RAM, 4-bit byte-enable write, 1-cycle synchronous read.
//   Infers BRAM.
// TESTING
//  1 WAIT_CYCLES=0: SW 0xDEADBEEF @0x10000, then LW @0x10000
//    -> RSP_RDATA=0xDEADBEEF, ERR=0; each RSP_VALID 2 cycles after accept.
//  2 SB 0x80 @0x10001, then LB and LBU @0x10001
//    -> 0xFFFFFF80 and 0x00000080; LW @0x10000 -> 0xDEAD80EF.
//  3 LW @0x0000FFFC and @BASE+4*DEPTH -> ERR=1, RDATA=0; no RAM word changed.
//  4 WAIT_CYCLES=3, RSP_READY low 5 cycles -> RSP_VALID at +5, held with stable data;
//    REQ_READY=0 until the cycle after the handshake.
//  5 LH @0x10003: with MISALIGN_TRAP_EN -> ERR=1;
//    without it -> sign-extended half from lanes 2..3 (0xFFFFDEAD).
//  6 Assert RST during WAIT of an SW -> target word unchanged, RSP_VALID never asserted,
//    REQ_READY=1 after reset.

Source files
------------

// File: rtl/rip_mem_pkg.sv
// Shared types and helpers for the data-memory responder: funct3 codes,
// FSM state encoding, the registered request record, and the lane
// steering / extension functions used by rip_dmem_responder.
package rip_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Loads accept B/H/W/BU/HU, stores only B/H/W.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return lane != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Halves use lane[1] only and words ignore the lane, which forces
  // natural alignment when misaligned accesses are not trapped.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_B:    return 4'b0001 << lane;
      F3_H:    return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the LSB-aligned store data into every lane; the byte
  // enables pick the lanes that are actually written.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/rip_dmem_bank.sv
// DEPTH x 32 data RAM with per-byte write enables and a registered,
// enabled read port; written in the single-port byte-write BRAM template.
module rip_dmem_bank #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write and enabled synchronous read; rdata holds between reads.
  // NOTE: no reset on the array or rdata -- a reset branch would stop the tools mapping this to block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      // NOTE: non-blocking assignments keep every register update in this block ordered as one clock edge.
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/rip_dmem_responder.sv
// Memory-side responder for the core load/store port: one request at a
// time over valid/ready, optional wait states, byte-lane steering for
// stores and sign/zero extension for loads.
// Optional feature: define RIP_DMEM_MISALIGN_TRAP_EN to report misaligned
// halfword/word accesses as errors instead of forcing natural alignment.
module rip_dmem_responder
  import rip_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_t   state_q;
  mem_req_t      req_q;
  logic [3:0]    cnt_q;
  logic          err_q;

  logic [31:0]   offset;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic          acc_err;
  logic [3:0]    bank_we;
  logic          bank_re;
  logic [31:0]   bank_wdata;
  logic [31:0]   bank_rdata;

  // Decode the registered request into RAM controls; only ACCESS touches the bank.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    bank_we    = 4'b0000;
    bank_re    = 1'b0;
    offset     = req_q.addr - BASE_ADDR;
    lane       = req_q.addr[1:0];
    word_idx   = offset[AW+1:2];
    bank_wdata = store_data(req_q.funct3, req_q.wdata);
`ifdef RIP_DMEM_MISALIGN_TRAP_EN
    misaligned = is_misaligned(req_q.funct3, lane);
`else
    misaligned = 1'b0;
`endif
    acc_err = !funct3_legal(req_q.we, req_q.funct3) || (offset >= SPAN) || misaligned;
    if (state_q == ACCESS && !acc_err) begin
      if (req_q.we) bank_we = store_be(req_q.funct3, lane);
      else          bank_re = 1'b1;
    end
  end

  // Request FSM: capture on accept, count wait states, access, hold the response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (REQ_VALID && REQ_READY) begin
          req_q   <= '{we: REQ_WE, funct3: REQ_FUNCT3, addr: REQ_ADDR, wdata: REQ_WDATA};
          cnt_q   <= WAIT_INIT;
          state_q <= (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ACCESS;
        end
        ACCESS: begin
          err_q   <= acc_err;
          state_q <= RESP;
        end
        RESP: if (RSP_READY) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The write enable is not gated by RST, so a reset landing on the ACCESS
  // edge still lets the store complete while the response is dropped.
  rip_dmem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk   (CLK),
    .we    (bank_we),
    .re    (bank_re),
    .addr  (word_idx),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  assign REQ_READY = (state_q == IDLE);
  assign RSP_VALID = (state_q == RESP);
  assign RSP_ERR   = RSP_VALID && err_q;
  assign RSP_RDATA = (RSP_VALID && !err_q && !req_q.we)
                   ? load_extend(bank_rdata, req_q.funct3, req_q.addr[1:0]) : 32'h0;

endmodule

// File: tb/tb_rip_dmem_responder.sv
// Directed bench for rip_dmem_responder: a zero-wait instance (index 0)
// and a three-wait-state instance (index 1) share clock and reset.
module tb_rip_dmem_responder;
  import rip_mem_pkg::*;

  logic        clk, rst;
  logic        req_valid [2], req_ready [2], req_we [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  logic        rsp_valid [2], rsp_ready [2], rsp_err [2];

  int n_vec  = 0;
  int n_fail = 0;

  rip_dmem_responder #(.WAIT_CYCLES(0)) u_fast (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]), .REQ_WE(req_we[0]),
    .REQ_FUNCT3(req_funct3[0]), .REQ_ADDR(req_addr[0]), .REQ_WDATA(req_wdata[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]),
    .RSP_RDATA(rsp_rdata[0]), .RSP_ERR(rsp_err[0])
  );

  rip_dmem_responder #(.WAIT_CYCLES(3)) u_slow (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]), .REQ_WE(req_we[1]),
    .REQ_FUNCT3(req_funct3[1]), .REQ_ADDR(req_addr[1]), .REQ_WDATA(req_wdata[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]),
    .RSP_RDATA(rsp_rdata[1]), .RSP_ERR(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One complete transaction with RSP_READY held high; checks latency from
  // the accept cycle to the first RSP_VALID cycle, then data and error.
  task automatic xact(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input string tag);
    int n;
    int lat;
    @(negedge clk);
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    rsp_ready[d]  = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, rsp_rdata[d], exp_rdata);
    check({tag, " err"}, {31'h0, rsp_err[d]}, {31'h0, exp_err});
  endtask

  initial begin
    int lat;
    int seen;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'b000;
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0; rsp_ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state on both instances.
    for (int i = 0; i < 2; i++) begin
      check("reset req_ready", {31'h0, req_ready[i]}, 32'h1);
      check("reset rsp_valid", {31'h0, rsp_valid[i]}, 32'h0);
      check("reset rsp_rdata", rsp_rdata[i], 32'h0);
      check("reset rsp_err",   {31'h0, rsp_err[i]}, 32'h0);
    end

    // Word store / load round trip, two-cycle latency.
    xact(0, 1'b1, F3_W,  32'h0001_0000, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, "sw base");
    xact(0, 1'b0, F3_W,  32'h0001_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, "lw base");

    // Byte store into lane 1, signed and unsigned byte loads.
    xact(0, 1'b1, F3_B,  32'h0001_0001, 32'h0000_0080, 32'h0,         1'b0, 2, "sb lane1");
    xact(0, 1'b0, F3_B,  32'h0001_0001, 32'h0,         32'hFFFF_FF80, 1'b0, 2, "lb lane1");
    xact(0, 1'b0, F3_BU, 32'h0001_0001, 32'h0,         32'h0000_0080, 1'b0, 2, "lbu lane1");
    xact(0, 1'b0, F3_W,  32'h0001_0000, 32'h0,         32'hDEAD_80EF, 1'b0, 2, "lw after sb");
    xact(0, 1'b0, F3_HU, 32'h0001_0002, 32'h0,         32'h0000_DEAD, 1'b0, 2, "lhu upper");

    // Range and funct3 errors: no write, zero data, normal latency.
    xact(0, 1'b1, F3_W,  32'h0001_3FFC, 32'h1122_3344, 32'h0,         1'b0, 2, "sw last word");
    xact(0, 1'b0, F3_W,  32'h0000_FFFC, 32'h0,         32'h0,         1'b1, 2, "lw below base");
    xact(0, 1'b0, F3_W,  32'h0001_4000, 32'h0,         32'h0,         1'b1, 2, "lw past end");
    xact(0, 1'b1, F3_W,  32'h0000_FFFC, 32'hBAD0_BAD0, 32'h0,         1'b1, 2, "sw below base");
    xact(0, 1'b1, F3_W,  32'h0001_4000, 32'hBAD1_BAD1, 32'h0,         1'b1, 2, "sw past end");
    xact(0, 1'b1, F3_BU, 32'h0001_0000, 32'h0000_0000, 32'h0,         1'b1, 2, "store bad f3");
    xact(0, 1'b0, 3'b011, 32'h0001_0000, 32'h0,        32'h0,         1'b1, 2, "load bad f3");
    xact(0, 1'b0, F3_W,  32'h0001_3FFC, 32'h0,         32'h1122_3344, 1'b0, 2, "last word kept");
    xact(0, 1'b0, F3_W,  32'h0001_0000, 32'h0,         32'hDEAD_80EF, 1'b0, 2, "word0 kept");

    // Misaligned halfword load.
`ifdef RIP_DMEM_MISALIGN_TRAP_EN
    xact(0, 1'b0, F3_H,  32'h0001_0003, 32'h0,         32'h0,         1'b1, 2, "lh misaligned");
`else
    xact(0, 1'b0, F3_H,  32'h0001_0003, 32'h0,         32'hFFFF_DEAD, 1'b0, 2, "lh misaligned");
`endif

    // Halfword store into the upper half, then a misaligned word store.
    xact(0, 1'b1, F3_W,  32'h0001_0004, 32'h0000_0000, 32'h0,         1'b0, 2, "sw clear w1");
    xact(0, 1'b1, F3_H,  32'h0001_0006, 32'h0000_CAFE, 32'h0,         1'b0, 2, "sh upper");
    xact(0, 1'b0, F3_W,  32'h0001_0004, 32'h0,         32'hCAFE_0000, 1'b0, 2, "lw after sh");
    xact(0, 1'b0, F3_H,  32'h0001_0006, 32'h0,         32'hFFFF_CAFE, 1'b0, 2, "lh upper");
`ifdef RIP_DMEM_MISALIGN_TRAP_EN
    xact(0, 1'b1, F3_W,  32'h0001_0005, 32'hFFFF_FFFF, 32'h0,         1'b1, 2, "sw misaligned");
    xact(0, 1'b0, F3_W,  32'h0001_0004, 32'h0,         32'hCAFE_0000, 1'b0, 2, "lw after bad sw");
`else
    xact(0, 1'b1, F3_W,  32'h0001_0005, 32'hFFFF_FFFF, 32'h0,         1'b0, 2, "sw misaligned");
    xact(0, 1'b0, F3_W,  32'h0001_0004, 32'h0,         32'hFFFF_FFFF, 1'b0, 2, "lw after bad sw");
`endif

    // Three wait states: latency five, response held while RSP_READY is low.
    xact(1, 1'b1, F3_W,  32'h0001_0008, 32'h55AA_55AA, 32'h0,         1'b0, 5, "slow sw");
    @(negedge clk);
    req_we[1] = 1'b0; req_funct3[1] = F3_W; req_addr[1] = 32'h0001_0008;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
    check("slow ready before accept", {31'h0, req_ready[1]}, 32'h1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    lat = 1;
    while (!rsp_valid[1] && lat < 50) begin
      check("slow ready while busy", {31'h0, req_ready[1]}, 32'h0);
      @(negedge clk);
      lat++;
    end
    check("slow stall latency", 32'(lat), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("stall rsp_valid", {31'h0, rsp_valid[1]}, 32'h1);
      check("stall rsp_rdata", rsp_rdata[1], 32'h55AA_55AA);
      check("stall req_ready", {31'h0, req_ready[1]}, 32'h0);
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    check("after hs rsp_valid", {31'h0, rsp_valid[1]}, 32'h0);
    check("after hs req_ready", {31'h0, req_ready[1]}, 32'h1);

    // Reset during WAIT of a store: request dropped, no write, no response.
    @(negedge clk);
    req_we[1] = 1'b1; req_funct3[1] = F3_W; req_addr[1] = 32'h0001_0008;
    req_wdata[1] = 32'h0BAD_F00D; req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("wait req_ready", {31'h0, req_ready[1]}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post rst req_ready", {31'h0, req_ready[1]}, 32'h1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid[1]) seen++;
      @(negedge clk);
    end
    check("post rst no response", 32'(seen), 32'd0);
    xact(1, 1'b0, F3_W,  32'h0001_0008, 32'h0,         32'h55AA_55AA, 1'b0, 5, "word kept after rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
